// File: rtl/jpeg_dma_pp.sv
// Double-buffered block DMA: fetches frame blocks over Wishbone into two BRAM banks, handing each to the DCT.
// Optional STATUS[31:16] cycle counter enabled by defining JPEG_DMA_PP_CYCCNT_EN.
module jpeg_dma_pp #(
   parameter int BLK_W   = 8,
   parameter int BLK_H   = 8,
   parameter int BANK_AW = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [31:0]        wb_adr_i,
   input  logic [31:0]        wb_dat_i,
   input  logic               wb_we_i,
   input  logic               dmaen_i,
   output logic [31:0]        wb_dat_o,
   output logic [31:0]        wbm_adr_o,
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic               wbm_we_o,
   output logic [3:0]         wbm_sel_o,
   output logic [31:0]        wbm_dat_o,
   input  logic               wbm_ack_i,
   input  logic [31:0]        wbm_dat_i,
   output logic [31:0]        dma_bram_data_o,
   output logic [BANK_AW:0]   dma_bram_addr_o,
   output logic               dma_bram_we_o,
   output logic               start_dct_o,
   output logic               dct_bank_o,
   input  logic               dct_busy_i
);

   localparam int                 WPL     = BLK_W / 4;
   localparam logic [BANK_AW-1:0] WMASK   = BANK_AW'(WPL - 1);
   localparam logic [31:0]        BLK_W32 = 32'(BLK_W);
   localparam logic [31:0]        BLK_H32 = 32'(BLK_H);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RELEASE, S_WAIT, S_DONE} state_t;

   state_t              state;
   logic [31:0]         srcaddr, addr, line_base, blk_base, row_base;
   logic [11:0]         pitch;
   logic [7:0]          endx, endy, bx, by;
   logic [BANK_AW-1:0]  widx;
   logic                fill_bank, dct_bank, dct_active, go_pending, frame_done;
   logic [1:0]          occ, occ_n;
   logic [15:0]         cyccnt;

   logic [2:0]          rsel;
   logic                reg_wr, ctrl_wr, start_wr, next_wr, abort_wr, start_acc;
   logic                fetch_ack, last_word, last_blk, last_frame, blk_end, rel;
   logic                running, dct_ready;
   logic [31:0]         pitch32, line_next, blk_next, row_next, status;
   logic                unused;

   assign unused    = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

   assign rsel      = wb_adr_i[4:2];
   assign reg_wr    = dmaen_i & wb_we_i;
   assign ctrl_wr   = reg_wr && (rsel == 3'd4);
   assign start_wr  = ctrl_wr & wb_dat_i[0];
   assign next_wr   = ctrl_wr & wb_dat_i[1];
   assign abort_wr  = ctrl_wr & wb_dat_i[2];
   assign start_acc = start_wr && !abort_wr && (state == S_IDLE);

   assign fetch_ack  = (state == S_FETCH) && wbm_ack_i;
   assign last_word  = ((widx & WMASK) == WMASK);
   assign last_blk   = &widx;
   assign last_frame = (bx == endx) && (by == endy);
   assign blk_end    = fetch_ack && last_blk;
   assign rel        = next_wr && dct_active;

   assign pitch32   = {20'd0, pitch};
   assign line_next = line_base + pitch32;
   assign blk_next  = blk_base + BLK_W32;
   assign row_next  = row_base + pitch32 * BLK_H32;

   // A block end and a bank release in the same cycle cancel out.
   always_comb begin
      occ_n = occ;
      if (blk_end && !rel)
         occ_n = occ + 2'd1;
      else if (!blk_end && rel)
         occ_n = occ - 2'd1;
   end

   assign running   = (state != S_IDLE);
   assign dct_ready = (occ != 2'd0) && !dct_active && !go_pending && !dct_busy_i;

   assign wbm_adr_o       = addr;
   assign wbm_cyc_o       = (state == S_FETCH);
   assign wbm_stb_o       = wbm_cyc_o;
   assign wbm_we_o        = 1'b0;
   assign wbm_sel_o       = 4'hF;
   assign wbm_dat_o       = '0;
   assign dma_bram_data_o = wbm_dat_i;
   assign dma_bram_addr_o = {fill_bank, widx};
   assign dma_bram_we_o   = fetch_ack;
   assign start_dct_o     = (occ != 2'd0) && !dct_active && go_pending && !dct_busy_i;
   assign dct_bank_o      = dct_bank;

   assign status = {cyccnt, 11'd0, occ, frame_done, dct_ready, running};

   always_comb begin
      wb_dat_o = '0;
      case (rsel)
         3'd0:    wb_dat_o = srcaddr;
         3'd1:    wb_dat_o = pitch32;
         3'd2:    wb_dat_o = {24'd0, endx};
         3'd3:    wb_dat_o = {24'd0, endy};
         3'd4:    wb_dat_o = status;
         default: wb_dat_o = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= S_IDLE;
         srcaddr    <= '0;
         pitch      <= '0;
         endx       <= '0;
         endy       <= '0;
         addr       <= '0;
         line_base  <= '0;
         blk_base   <= '0;
         row_base   <= '0;
         widx       <= '0;
         bx         <= '0;
         by         <= '0;
         fill_bank  <= 1'b0;
         dct_bank   <= 1'b0;
         occ        <= '0;
         dct_active <= 1'b0;
         go_pending <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (reg_wr) begin
            case (rsel)
               3'd0:    srcaddr <= wb_dat_i;
               3'd1:    pitch   <= wb_dat_i[11:0];
               3'd2:    endx    <= wb_dat_i[7:0];
               3'd3:    endy    <= wb_dat_i[7:0];
               default: ;
            endcase
         end

         if (abort_wr) begin
            state      <= S_IDLE;
            occ        <= '0;
            dct_active <= 1'b0;
            go_pending <= 1'b0;
         end else if (start_acc) begin
            state      <= S_FETCH;
            addr       <= srcaddr;
            line_base  <= srcaddr;
            blk_base   <= srcaddr;
            row_base   <= srcaddr;
            widx       <= '0;
            bx         <= '0;
            by         <= '0;
            fill_bank  <= 1'b0;
            dct_bank   <= 1'b0;
            occ        <= '0;
            dct_active <= 1'b0;
            go_pending <= 1'b1;
            frame_done <= 1'b0;
         end else begin
            occ <= occ_n;
            if (start_dct_o) begin
               dct_active <= 1'b1;
               go_pending <= 1'b0;
            end
            if (next_wr) begin
               go_pending <= 1'b1;
               if (dct_active) begin
                  dct_active <= 1'b0;
                  dct_bank   <= ~dct_bank;
               end
            end

            case (state)
               S_FETCH: begin
                  if (wbm_ack_i) begin
                     widx <= widx + 1'b1;
                     if (last_blk) begin
                        fill_bank <= ~fill_bank;
                        if (last_frame)
                           state <= S_DONE;
                        else if (occ_n == 2'd2)
                           state <= S_WAIT;
                        else
                           state <= S_RELEASE;
                        // Next block starts either one block right or at the next block row.
                        if (bx == endx) begin
                           bx        <= '0;
                           by        <= by + 8'd1;
                           row_base  <= row_next;
                           blk_base  <= row_next;
                           line_base <= row_next;
                           addr      <= row_next;
                        end else begin
                           bx        <= bx + 8'd1;
                           blk_base  <= blk_next;
                           line_base <= blk_next;
                           addr      <= blk_next;
                        end
                     end else if (last_word) begin
                        line_base <= line_next;
                        addr      <= line_next;
                        state     <= S_RELEASE;
                     end else begin
                        addr <= addr + 32'd4;
                     end
                  end
               end
               S_RELEASE: state <= S_FETCH;
               S_WAIT:    if (occ < 2'd2) state <= S_RELEASE;
               S_DONE: begin
                  if (occ == 2'd0) begin
                     state      <= S_IDLE;
                     frame_done <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef JPEG_DMA_PP_CYCCNT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         cyccnt <= '0;
      else if (start_acc || next_wr)
         cyccnt <= '0;
      else if ((running || dct_busy_i) && (cyccnt != 16'hFFFF))
         cyccnt <= cyccnt + 16'd1;
   end
`else
   assign cyccnt = '0;
`endif

endmodule
